groups_sequencer: RTL and testbench
===================================

# groups_sequencer

Initiator for the `groups` accelerator dispatcher. It accepts one instruction at a time from the CV-X-IF issue side, streams operand pairs into the target group as fill commands, and fires exec. For multi-output instructions it then collects the remaining outputs with pick commands. Every result word coming back (exec completion or pick) is queued in a result FIFO. That FIFO drives the writeback side with valid/ready backpressure; `groups` itself offers none.

## Interface
Parameters:
- `inputWidth`, 64: width of one operand half; fill carries two halves.
- `outputWidth`, 64: result word width.
- `opcodeWidth`, 8: opcode width.
- `inputIndexWidth`, 3: fill index width.
- `outputIndexWidth`, 2: pick index width.
- `ResFifoDepth`, 4: result FIFO entries (power of two, ≥2).
- `instr_id_t`, `logic [X_ID_WIDTH-1:0]`: instruction id type from `cvxif_pkg`.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `req_valid_i` / `req_ready_o` in/out 1: instruction handshake.
- `req_opcode_i` in opcodeWidth: opcode.
- `req_id_i` in instr_id_t: instruction id.
- `req_num_fill_i` in inputIndexWidth+1: operand pairs, 0..2^inputIndexWidth.
- `req_num_pick_i` in outputIndexWidth: extra outputs after the exec result.
- `opnd_valid_i` / `opnd_ready_o` in/out 1: operand stream handshake.
- `opnd_data_i` in 2×inputWidth: operand pair.
- `exec_o`, `opcode_o`, `instr_id_o`: out to `groups` `exec_i`, `opcode_i`, `instr_id_i`.
- `in_data_vld_o`, `in_idx_o`, `in_data_o`: out, fill command.
- `out_data_vld_o`, `out_idx_o`: out, pick command.
- `invalid_instr_i`, `busy_i`, `done_i`, `out_data_i`, `instr_id_i`: in from `groups`.
- `res_valid_o` / `res_ready_i` out/in 1: result handshake.
- `res_id_o` out instr_id_t: result instruction id.
- `res_data_o` out outputWidth: result word.
- `res_last_o` out 1: final word of the instruction.
- `res_err_o` out 1: instruction was invalid; data is zero.

## Operation
- **Opcode hold:** `opcode_o` and `instr_id_o` come from the current-instruction registers and are held stable from accept until return to IDLE, so `busy_i` and `invalid_instr_i` refer to the current instruction.
- **Credits:** `credit = fifo_count + inflight_execs`.
  - `inflight_execs` increments on `exec_o` and decrements on `done_i`.
  - Any action that will produce a FIFO entry (exec, pick, error push) requires `credit < ResFifoDepth`.
- **FSM states:**
  - **IDLE:** `req_ready_o=1`. On handshake, latch opcode, id and counts, and clear the fill counter. Next state is FILL, or EXEC if num_fill=0.
  - **FILL:**
    - `opnd_ready_o = !busy_i`.
    - On each operand beat: `in_data_vld_o=1`, `in_idx_o=fill_cnt`, `in_data_o=opnd_data_i`, then increment the counter.
    - After the last beat, go to EXEC.
    - If `invalid_instr_i`: `in_data_vld_o` is forced 0 and beats are still consumed (discarded); after the last beat go to ERR.
  - **EXEC:**
    - If `invalid_instr_i`, go to ERR.
    - Otherwise assert `exec_o` for one cycle when `!busy_i` and a credit is available.
    - Then go to IDLE if num_pick=0, else WAIT.
  - **WAIT:** stay until `done_i && instr_id_i==cur_id`, then go to PICK with `pick_cnt=1`.
  - **PICK:**
    - When a credit is available: `out_data_vld_o=1`, `out_idx_o=pick_cnt`.
    - Push {cur_id, `out_data_i`, last = (pick_cnt==num_pick), err=0} the same cycle.
    - After the final pick, go to IDLE.
  - **ERR:** push {cur_id, 0, last=1, err=1} in the first cycle with a credit and `!done_i`, then go to IDLE.
- **FIFO pushes:**
  - `done_i` always pushes {`instr_id_i`, `out_data_i`, last=(num_pick of that instruction == 0), err=0}.
  - For this, a per-id flag is recorded at exec: the sequencer keeps the id of the single outstanding multi-output exec.
  - `groups` suppresses `done_i` in pick cycles, so at most one push occurs per cycle.
  - FIFO pop occurs on `res_valid_o && res_ready_i`. A push and a pop in the same cycle are both honoured, including when full.
- Command outputs are 0 whenever not actively asserted.

## Timing
- **Reset values:**
  - All strobes, `req_ready_o`, `opnd_ready_o`, `res_valid_o`, and all counters are 0.
  - FSM is in IDLE; `req_ready_o` rises the first cycle after reset.
- **Latency:**
  - Accept in cycle 0.
  - Fills in cycles 1..N at best, one per cycle.
  - Exec in cycle N+1.
  - For num_pick=0, the next instruction can be accepted at N+2.
- A FIFO entry is visible on `res_*` the cycle after its push (registered FIFO).
- **Reset mid-operation:** the FSM returns to IDLE, and the FIFO and credits are cleared. In-flight `groups` state is the integrator's concern.
- **Fill counter:** 4'b1000 with inputIndexWidth=3 is legal as a count; the index never exceeds 3'b111.

## Test plan
- **Basic exec:** num_fill=2, num_pick=0, `groups` returns done with data 0xA5 three cycles after exec.
  - Fills at idx 0,1; exec one cycle after the last fill.
  - One result {id, 0xA5, last=1, err=0}.
- **Busy stall:** `busy_i=1` for 5 cycles during FILL.
  - `opnd_ready_o=0` and no `in_data_vld_o`.
  - Fills resume when `busy_i` drops.
- **Invalid opcode:** `invalid_instr_i=1`, num_fill=3.
  - Three beats consumed with no fill strobes and no exec.
  - Result {id, 0, last=1, err=1}.
- **Multi-output:** num_pick=2.
  - Exec, then done (last=0), then picks at idx 1 and 2.
  - Three results in order, last only on the third.
- **Backpressure:** `res_ready_i=0`, issue 5 single-output instructions with depth 4.
  - Fifth exec withheld until a pop.
  - No result is lost.
- **Reset during WAIT:**
  - All outputs return to 0 and FIFO is empty.
  - `req_ready_o=1` one cycle after release.

Source files
------------

// File: rtl/groups_sequencer.sv
// Issue-side sequencer for the groups dispatcher: fills operands, fires exec, collects
// picks, and buffers every result word in a credit-guarded FIFO towards writeback.
module groups_sequencer #(
    parameter int  inputWidth       = 64,
    parameter int  outputWidth      = 64,
    parameter int  opcodeWidth      = 8,
    parameter int  inputIndexWidth  = 3,
    parameter int  outputIndexWidth = 2,
    parameter int  ResFifoDepth     = 4,
    parameter type instr_id_t       = logic [3:0]
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [opcodeWidth-1:0]        req_opcode_i,
    input  instr_id_t                     req_id_i,
    input  logic [inputIndexWidth:0]      req_num_fill_i,
    input  logic [outputIndexWidth-1:0]   req_num_pick_i,
    input  logic                          opnd_valid_i,
    output logic                          opnd_ready_o,
    input  logic [2*inputWidth-1:0]       opnd_data_i,
    output logic                          exec_o,
    output logic [opcodeWidth-1:0]        opcode_o,
    output instr_id_t                     instr_id_o,
    output logic                          in_data_vld_o,
    output logic [inputIndexWidth-1:0]    in_idx_o,
    output logic [2*inputWidth-1:0]       in_data_o,
    output logic                          out_data_vld_o,
    output logic [outputIndexWidth-1:0]   out_idx_o,
    input  logic                          invalid_instr_i,
    input  logic                          busy_i,
    input  logic                          done_i,
    input  logic [outputWidth-1:0]        out_data_i,
    input  instr_id_t                     instr_id_i,
    output logic                          res_valid_o,
    input  logic                          res_ready_i,
    output instr_id_t                     res_id_o,
    output logic [outputWidth-1:0]        res_data_o,
    output logic                          res_last_o,
    output logic                          res_err_o
);

    localparam int IdW    = $bits(instr_id_t);
    localparam int PtrW   = $clog2(ResFifoDepth);
    localparam int CntW   = PtrW + 1;
    localparam int CrW    = PtrW + 2;
    localparam int FillW  = inputIndexWidth + 1;
    localparam int EntryW = IdW + outputWidth + 2;

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StFill = 3'd1;
    localparam logic [2:0] StExec = 3'd2;
    localparam logic [2:0] StWait = 3'd3;
    localparam logic [2:0] StPick = 3'd4;
    localparam logic [2:0] StErr  = 3'd5;

    logic [2:0]                  state_q, state_d;
    logic                        ready_en_q, ready_en_d;
    logic [opcodeWidth-1:0]      opcode_q, opcode_d;
    instr_id_t                   id_q, id_d;
    logic [FillW-1:0]            num_fill_q, num_fill_d;
    logic [outputIndexWidth-1:0] num_pick_q, num_pick_d;
    logic [FillW-1:0]            fill_cnt_q, fill_cnt_d;
    logic [outputIndexWidth-1:0] pick_cnt_q, pick_cnt_d;
    logic [CrW-1:0]              inflight_q, inflight_d;
    instr_id_t                   multi_id_q, multi_id_d;
    logic                        multi_vld_q, multi_vld_d;
    logic [EntryW-1:0]           fifo_mem_q [ResFifoDepth];
    logic [EntryW-1:0]           fifo_mem_d [ResFifoDepth];
    logic [PtrW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]             count_q, count_d;

    logic              credit_ok, push, push_ok, pop, full, multi_hit;
    logic [EntryW-1:0] push_entry, head;

    // Every exec reserves a FIFO slot until its done arrives, so pushes can never overflow
    assign credit_ok = (CrW'(count_q) + inflight_q) < CrW'(ResFifoDepth);
    assign multi_hit = multi_vld_q && (instr_id_i == multi_id_q);
    assign full      = count_q == CntW'(ResFifoDepth);
    assign pop       = res_valid_o && res_ready_i;
    assign push_ok   = push && (!full || pop);

    assign res_valid_o = count_q != '0;
    assign head        = res_valid_o ? fifo_mem_q[rd_ptr_q] : '0;
    assign {res_id_o, res_data_o, res_last_o, res_err_o} = head;

    assign opcode_o   = (state_q != StIdle) ? opcode_q : '0;
    assign instr_id_o = (state_q != StIdle) ? id_q : '0;

    always_comb begin
        state_d        = state_q;
        ready_en_d     = 1'b1;
        opcode_d       = opcode_q;
        id_d           = id_q;
        num_fill_d     = num_fill_q;
        num_pick_d     = num_pick_q;
        fill_cnt_d     = fill_cnt_q;
        pick_cnt_d     = pick_cnt_q;
        multi_id_d     = multi_id_q;
        multi_vld_d    = multi_vld_q;
        req_ready_o    = 1'b0;
        opnd_ready_o   = 1'b0;
        exec_o         = 1'b0;
        in_data_vld_o  = 1'b0;
        in_idx_o       = '0;
        in_data_o      = '0;
        out_data_vld_o = 1'b0;
        out_idx_o      = '0;
        push           = 1'b0;
        push_entry     = '0;

        // groups never raises done in a pick cycle, so the state pushes below only win when done is low
        if (done_i) begin
            push       = 1'b1;
            push_entry = {instr_id_i, out_data_i, !multi_hit, 1'b0};
            if (multi_hit) multi_vld_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                req_ready_o = ready_en_q;
                if (req_valid_i && ready_en_q) begin
                    opcode_d   = req_opcode_i;
                    id_d       = req_id_i;
                    num_fill_d = req_num_fill_i;
                    num_pick_d = req_num_pick_i;
                    fill_cnt_d = '0;
                    state_d    = (req_num_fill_i == '0) ? StExec : StFill;
                end
            end
            StFill: begin
                opnd_ready_o = !busy_i;
                if (opnd_valid_i && !busy_i) begin
                    if (!invalid_instr_i) begin
                        in_data_vld_o = 1'b1;
                        in_idx_o      = fill_cnt_q[inputIndexWidth-1:0];
                        in_data_o     = opnd_data_i;
                    end
                    fill_cnt_d = fill_cnt_q + FillW'(1);
                    if (fill_cnt_q + FillW'(1) == num_fill_q)
                        state_d = invalid_instr_i ? StErr : StExec;
                end
            end
            StExec: begin
                if (invalid_instr_i) begin
                    state_d = StErr;
                end else if (!busy_i && credit_ok) begin
                    exec_o = 1'b1;
                    if (num_pick_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        state_d     = StWait;
                        multi_id_d  = id_q;
                        multi_vld_d = 1'b1;
                    end
                end
            end
            StWait: begin
                if (done_i && instr_id_i == id_q) begin
                    state_d    = StPick;
                    pick_cnt_d = outputIndexWidth'(1);
                end
            end
            StPick: begin
                if (credit_ok && !done_i) begin
                    out_data_vld_o = 1'b1;
                    out_idx_o      = pick_cnt_q;
                    push           = 1'b1;
                    push_entry     = {id_q, out_data_i, pick_cnt_q == num_pick_q, 1'b0};
                    pick_cnt_d     = pick_cnt_q + outputIndexWidth'(1);
                    if (pick_cnt_q == num_pick_q) state_d = StIdle;
                end
            end
            StErr: begin
                if (credit_ok && !done_i) begin
                    push       = 1'b1;
                    push_entry = {id_q, outputWidth'(0), 1'b1, 1'b1};
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        inflight_d = inflight_q + CrW'(exec_o) - CrW'(done_i && inflight_q != '0);

        // A full FIFO still accepts a push when the head leaves in the same cycle
        fifo_mem_d = fifo_mem_q;
        if (push_ok) fifo_mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d = wr_ptr_q + PtrW'(push_ok);
        rd_ptr_d = rd_ptr_q + PtrW'(pop);
        count_d  = count_q + CntW'(push_ok) - CntW'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            ready_en_q  <= 1'b0;
            opcode_q    <= '0;
            id_q        <= '0;
            num_fill_q  <= '0;
            num_pick_q  <= '0;
            fill_cnt_q  <= '0;
            pick_cnt_q  <= '0;
            inflight_q  <= '0;
            multi_id_q  <= '0;
            multi_vld_q <= 1'b0;
            fifo_mem_q  <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            ready_en_q  <= ready_en_d;
            opcode_q    <= opcode_d;
            id_q        <= id_d;
            num_fill_q  <= num_fill_d;
            num_pick_q  <= num_pick_d;
            fill_cnt_q  <= fill_cnt_d;
            pick_cnt_q  <= pick_cnt_d;
            inflight_q  <= inflight_d;
            multi_id_q  <= multi_id_d;
            multi_vld_q <= multi_vld_d;
            fifo_mem_q  <= fifo_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

endmodule

// File: tb/tb_groups_sequencer.sv
// Directed bench for groups_sequencer with a small behavioural groups model
// (done three cycles after exec, pick data 0xB0 + index).
module tb_groups_sequencer;

    typedef logic [3:0] id_t;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         req_valid_i = 1'b0;
    logic         req_ready_o;
    logic [7:0]   req_opcode_i = '0;
    id_t          req_id_i = '0;
    logic [3:0]   req_num_fill_i = '0;
    logic [1:0]   req_num_pick_i = '0;
    logic         opnd_valid_i;
    logic         opnd_ready_o;
    logic [127:0] opnd_data_i;
    logic         exec_o;
    logic [7:0]   opcode_o;
    id_t          instr_id_o;
    logic         in_data_vld_o;
    logic [2:0]   in_idx_o;
    logic [127:0] in_data_o;
    logic         out_data_vld_o;
    logic [1:0]   out_idx_o;
    logic         invalid_instr_i = 1'b0;
    logic         busy_i = 1'b0;
    logic         done_i;
    logic [63:0]  out_data_i;
    id_t          instr_id_i;
    logic         res_valid_o;
    logic         res_ready_i = 1'b1;
    id_t          res_id_o;
    logic [63:0]  res_data_o;
    logic         res_last_o;
    logic         res_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    groups_sequencer #(
        .inputWidth(64), .outputWidth(64), .opcodeWidth(8), .inputIndexWidth(3),
        .outputIndexWidth(2), .ResFifoDepth(4), .instr_id_t(id_t)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_opcode_i(req_opcode_i),
        .req_id_i(req_id_i), .req_num_fill_i(req_num_fill_i), .req_num_pick_i(req_num_pick_i),
        .opnd_valid_i(opnd_valid_i), .opnd_ready_o(opnd_ready_o), .opnd_data_i(opnd_data_i),
        .exec_o(exec_o), .opcode_o(opcode_o), .instr_id_o(instr_id_o),
        .in_data_vld_o(in_data_vld_o), .in_idx_o(in_idx_o), .in_data_o(in_data_o),
        .out_data_vld_o(out_data_vld_o), .out_idx_o(out_idx_o),
        .invalid_instr_i(invalid_instr_i), .busy_i(busy_i), .done_i(done_i),
        .out_data_i(out_data_i), .instr_id_i(instr_id_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_id_o(res_id_o),
        .res_data_o(res_data_o), .res_last_o(res_last_o), .res_err_o(res_err_o)
    );

    always #5 clk_i = ~clk_i;

    // groups model: done and its id emerge three cycles after exec
    logic [2:0] pipe_vld;
    id_t        pipe_id [3];
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_vld <= '0;
            pipe_id  <= '{default: '0};
        end else begin
            pipe_vld   <= {pipe_vld[1:0], exec_o};
            pipe_id[0] <= instr_id_o;
            pipe_id[1] <= pipe_id[0];
            pipe_id[2] <= pipe_id[1];
        end
    end
    assign done_i     = pipe_vld[2];
    assign instr_id_i = pipe_id[2];
    assign out_data_i = out_data_vld_o ? (64'hB0 + 64'(out_idx_o)) : (done_i ? {60'hA, instr_id_i} : 64'h0);

    int opnd_offered = 0;
    int opnd_taken   = 0;
    assign opnd_valid_i = opnd_taken < opnd_offered;
    assign opnd_data_i  = {64'hC0DE, 64'(opnd_taken)};
    always @(posedge clk_i) if (opnd_valid_i && opnd_ready_o) opnd_taken <= opnd_taken + 1;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int           fill_idx_q[$];
    int           fill_cyc_q[$];
    logic [127:0] fill_data_q[$];
    int           exec_cyc_q[$];
    logic [7:0]   exec_op_q[$];
    int           pick_idx_q[$];
    int           accept_cyc_q[$];
    logic [69:0]  res_q[$];
    int           pop_cyc_q[$];

    // Mid-cycle monitor: everything seen here is what the next rising edge will commit
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (req_valid_i && req_ready_o) accept_cyc_q.push_back(cyc);
            if (in_data_vld_o) begin
                fill_idx_q.push_back(int'(in_idx_o));
                fill_cyc_q.push_back(cyc);
                fill_data_q.push_back(in_data_o);
            end
            if (exec_o) begin
                exec_cyc_q.push_back(cyc);
                exec_op_q.push_back(opcode_o);
            end
            if (out_data_vld_o) pick_idx_q.push_back(int'(out_idx_o));
            if (res_valid_o && res_ready_i) begin
                res_q.push_back({res_id_o, res_data_o, res_last_o, res_err_o});
                pop_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic clear_logs();
        fill_idx_q.delete(); fill_cyc_q.delete(); fill_data_q.delete();
        exec_cyc_q.delete(); exec_op_q.delete(); pick_idx_q.delete();
        accept_cyc_q.delete(); res_q.delete(); pop_cyc_q.delete();
    endtask

    task automatic apply_stimulus(input logic [7:0] op, input id_t id, input logic [3:0] nf, input logic [1:0] np);
        @(posedge clk_i); #1;
        req_valid_i = 1'b1; req_opcode_i = op; req_id_i = id;
        req_num_fill_i = nf; req_num_pick_i = np;
        opnd_offered = opnd_offered + int'(nf);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (req_ready_o) break;
        end
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_results(input int n);
        for (int i = 0; i < 200 && res_q.size() < n; i++) @(negedge clk_i);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        n_checks++; if (req_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req_ready: got %0h expected 0", req_ready_o); end
        n_checks++; if (res_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_res_valid: got %0h expected 0", res_valid_o); end
        n_checks++; if ({exec_o, in_data_vld_o, out_data_vld_o, opnd_ready_o} !== 4'b0) begin
            n_fail++; $display("[TB] FAIL reset_strobes: got %b expected 0000", {exec_o, in_data_vld_o, out_data_vld_o, opnd_ready_o});
        end
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        n_checks++; if (req_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL release_ready_early: got %0h expected 0", req_ready_o); end
        @(negedge clk_i);
        n_checks++; if (req_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL release_ready: got %0h expected 1", req_ready_o); end
    endtask

    task automatic test_basic_exec();
        int base;
        clear_logs();
        base = opnd_taken;
        apply_stimulus(8'h11, 4'd5, 4'd2, 2'd0);
        apply_stimulus(8'h12, 4'd6, 4'd0, 2'd0);
        wait_results(2);
        n_checks++; if (fill_idx_q.size() !== 2) begin n_fail++; $display("[TB] FAIL basic_fill_count: got %0d expected 2", fill_idx_q.size()); end
        else begin
            n_checks++; if (fill_idx_q[0] !== 0 || fill_idx_q[1] !== 1) begin n_fail++; $display("[TB] FAIL basic_fill_idx: got %0d,%0d expected 0,1", fill_idx_q[0], fill_idx_q[1]); end
            n_checks++; if (fill_data_q[1] !== {64'hC0DE, 64'(base + 1)}) begin n_fail++; $display("[TB] FAIL basic_fill_data: got %h expected %h", fill_data_q[1], {64'hC0DE, 64'(base + 1)}); end
            n_checks++; if (fill_cyc_q[0] - accept_cyc_q[0] !== 1 || exec_cyc_q[0] - fill_cyc_q[1] !== 1) begin
                n_fail++; $display("[TB] FAIL basic_latency: got fill+%0d exec+%0d expected fill+1 exec+1", fill_cyc_q[0] - accept_cyc_q[0], exec_cyc_q[0] - fill_cyc_q[1]);
            end
        end
        n_checks++; if (exec_op_q.size() !== 2 || exec_op_q[0] !== 8'h11) begin n_fail++; $display("[TB] FAIL basic_exec_opcode: got %0d execs op %h expected 2 execs op 11", exec_op_q.size(), exec_op_q[0]); end
        n_checks++; if (accept_cyc_q.size() !== 2 || accept_cyc_q[1] - accept_cyc_q[0] !== 4) begin
            n_fail++; $display("[TB] FAIL basic_next_accept: got %0d accepts gap %0d expected 2 gap 4", accept_cyc_q.size(), accept_cyc_q[1] - accept_cyc_q[0]);
        end
        n_checks++; if (res_q.size() !== 2) begin n_fail++; $display("[TB] FAIL basic_res_count: got %0d expected 2", res_q.size()); end
        else begin
            n_checks++; if (res_q[0] !== {4'd5, 64'hA5, 1'b1, 1'b0}) begin n_fail++; $display("[TB] FAIL basic_res0: got %h expected %h", res_q[0], {4'd5, 64'hA5, 1'b1, 1'b0}); end
            n_checks++; if (res_q[1] !== {4'd6, 64'hA6, 1'b1, 1'b0}) begin n_fail++; $display("[TB] FAIL basic_res1: got %h expected %h", res_q[1], {4'd6, 64'hA6, 1'b1, 1'b0}); end
        end
    endtask

    task automatic test_busy_stall();
        int  base;
        bit  stall_bad = 1'b0;
        clear_logs();
        base = opnd_taken;
        apply_stimulus(8'h22, 4'd8, 4'd4, 2'd0);
        busy_i = 1'b1;
        repeat (5) begin
            @(negedge clk_i);
            if (opnd_ready_o || in_data_vld_o) stall_bad = 1'b1;
        end
        n_checks++; if (stall_bad !== 1'b0 || fill_idx_q.size() !== 0) begin n_fail++; $display("[TB] FAIL busy_stall: got ready/fill %0b/%0d expected 0/0", stall_bad, fill_idx_q.size()); end
        @(posedge clk_i); #1;
        busy_i = 1'b0;
        wait_results(1);
        n_checks++; if (fill_idx_q.size() !== 4) begin n_fail++; $display("[TB] FAIL busy_fill_count: got %0d expected 4", fill_idx_q.size()); end
        else begin
            n_checks++; if (fill_idx_q[3] !== 3 || fill_data_q[3] !== {64'hC0DE, 64'(base + 3)}) begin n_fail++; $display("[TB] FAIL busy_last_fill: got idx %0d data %h expected idx 3", fill_idx_q[3], fill_data_q[3]); end
            n_checks++; if (fill_cyc_q[0] - accept_cyc_q[0] !== 6) begin n_fail++; $display("[TB] FAIL busy_resume: got %0d expected 6", fill_cyc_q[0] - accept_cyc_q[0]); end
        end
        n_checks++; if (res_q.size() !== 1 || res_q[0] !== {4'd8, 64'hA8, 1'b1, 1'b0}) begin n_fail++; $display("[TB] FAIL busy_res: got %h expected %h", res_q[0], {4'd8, 64'hA8, 1'b1, 1'b0}); end
    endtask

    task automatic test_invalid();
        int base;
        clear_logs();
        base = opnd_taken;
        invalid_instr_i = 1'b1;
        apply_stimulus(8'hFF, 4'd7, 4'd3, 2'd0);
        wait_results(1);
        invalid_instr_i = 1'b0;
        n_checks++; if (opnd_taken - base !== 3) begin n_fail++; $display("[TB] FAIL invalid_beats: got %0d expected 3", opnd_taken - base); end
        n_checks++; if (fill_idx_q.size() !== 0 || exec_cyc_q.size() !== 0) begin n_fail++; $display("[TB] FAIL invalid_strobes: got fills %0d execs %0d expected 0 0", fill_idx_q.size(), exec_cyc_q.size()); end
        n_checks++; if (res_q.size() !== 1 || res_q[0] !== {4'd7, 64'h0, 1'b1, 1'b1}) begin n_fail++; $display("[TB] FAIL invalid_res: got %h expected %h", res_q[0], {4'd7, 64'h0, 1'b1, 1'b1}); end
    endtask

    task automatic test_multi_output();
        clear_logs();
        apply_stimulus(8'h33, 4'd9, 4'd1, 2'd2);
        wait_results(3);
        n_checks++; if (exec_cyc_q.size() !== 1) begin n_fail++; $display("[TB] FAIL multi_exec_count: got %0d expected 1", exec_cyc_q.size()); end
        n_checks++; if (pick_idx_q.size() !== 2 || pick_idx_q[0] !== 1 || pick_idx_q[1] !== 2) begin
            n_fail++; $display("[TB] FAIL multi_pick_idx: got %0d picks %0d,%0d expected 2 picks 1,2", pick_idx_q.size(), pick_idx_q[0], pick_idx_q[1]);
        end
        n_checks++; if (res_q.size() !== 3) begin n_fail++; $display("[TB] FAIL multi_res_count: got %0d expected 3", res_q.size()); end
        else begin
            n_checks++; if (res_q[0] !== {4'd9, 64'hA9, 1'b0, 1'b0}) begin n_fail++; $display("[TB] FAIL multi_res0: got %h expected %h", res_q[0], {4'd9, 64'hA9, 1'b0, 1'b0}); end
            n_checks++; if (res_q[1] !== {4'd9, 64'hB1, 1'b0, 1'b0}) begin n_fail++; $display("[TB] FAIL multi_res1: got %h expected %h", res_q[1], {4'd9, 64'hB1, 1'b0, 1'b0}); end
            n_checks++; if (res_q[2] !== {4'd9, 64'hB2, 1'b1, 1'b0}) begin n_fail++; $display("[TB] FAIL multi_res2: got %h expected %h", res_q[2], {4'd9, 64'hB2, 1'b1, 1'b0}); end
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        res_ready_i = 1'b0;
        for (int i = 1; i <= 5; i++) apply_stimulus(8'h44, id_t'(i), 4'd0, 2'd0);
        repeat (10) @(negedge clk_i);
        n_checks++; if (exec_cyc_q.size() !== 4) begin n_fail++; $display("[TB] FAIL bp_exec_withheld: got %0d expected 4", exec_cyc_q.size()); end
        n_checks++; if (res_valid_o !== 1'b1 || res_q.size() !== 0) begin n_fail++; $display("[TB] FAIL bp_held: got valid %0b pops %0d expected 1 0", res_valid_o, res_q.size()); end
        res_ready_i = 1'b1;
        wait_results(5);
        n_checks++; if (exec_cyc_q.size() !== 5 || pop_cyc_q.size() == 0 || exec_cyc_q[4] <= pop_cyc_q[0]) begin
            n_fail++; $display("[TB] FAIL bp_fifth_exec: got %0d execs last at %0d first pop %0d expected 5 execs after pop", exec_cyc_q.size(), exec_cyc_q[4], pop_cyc_q[0]);
        end
        n_checks++; if (res_q.size() !== 5) begin n_fail++; $display("[TB] FAIL bp_res_count: got %0d expected 5", res_q.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (res_q[i] !== {id_t'(i + 1), {60'hA, 4'(i + 1)}, 1'b1, 1'b0}) begin
                    n_fail++; $display("[TB] FAIL bp_res%0d: got %h expected %h", i, res_q[i], {id_t'(i + 1), {60'hA, 4'(i + 1)}, 1'b1, 1'b0});
                end
            end
        end
    endtask

    task automatic test_reset_wait();
        clear_logs();
        res_ready_i = 1'b0;
        apply_stimulus(8'h55, 4'd2, 4'd0, 2'd0);
        for (int i = 0; i < 20 && !res_valid_o; i++) @(negedge clk_i);
        apply_stimulus(8'h66, 4'd3, 4'd0, 2'd1);
        @(posedge clk_i); #1;
        n_checks++; if (res_valid_o !== 1'b1 || exec_cyc_q.size() !== 2) begin n_fail++; $display("[TB] FAIL rstw_setup: got valid %0b execs %0d expected 1 2", res_valid_o, exec_cyc_q.size()); end
        rst_ni = 1'b0;
        @(negedge clk_i);
        n_checks++; if ({res_valid_o, req_ready_o, exec_o, out_data_vld_o, in_data_vld_o} !== 5'b0 || opcode_o !== 8'h0 || instr_id_o !== 4'h0) begin
            n_fail++; $display("[TB] FAIL rstw_outputs: got %b op %h id %h expected 00000 op 00 id 0", {res_valid_o, req_ready_o, exec_o, out_data_vld_o, in_data_vld_o}, opcode_o, instr_id_o);
        end
        repeat (4) @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        n_checks++; if (req_ready_o !== 1'b1 || res_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rstw_release: got ready %0b valid %0b expected 1 0", req_ready_o, res_valid_o); end
        clear_logs();
        res_ready_i = 1'b1;
        apply_stimulus(8'h77, 4'd4, 4'd1, 2'd0);
        wait_results(1);
        repeat (8) @(negedge clk_i);
        n_checks++; if (res_q.size() !== 1 || res_q[0] !== {4'd4, 64'hA4, 1'b1, 1'b0}) begin n_fail++; $display("[TB] FAIL rstw_after: got %0d results first %h expected 1 %h", res_q.size(), res_q[0], {4'd4, 64'hA4, 1'b1, 1'b0}); end
    endtask

    initial begin
        $display("[TB] groups_sequencer directed test start");
        test_reset();
        test_basic_exec();
        test_busy_stall();
        test_invalid();
        test_multi_output();
        test_back_to_back();
        test_reset_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
